// File: rtl/sha256_seq_pkg.sv
// Shared constants, FSM state type and address helper for the SHA-256 block sequencer.
// Optional block counter is enabled by defining SHA256_SEQ_BLKCNT_EN.
package sha256_seq_pkg;

  localparam logic [4:0]  MSG_BASE  = 5'd0;
  localparam logic [4:0]  DIG_BASE  = 5'd16;
  localparam logic [4:0]  CTRL_ADDR = 5'd24;
  localparam int unsigned MSG_WORDS = 16;
  localparam int unsigned DIG_WORDS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    READ,
    EMIT
  } seq_state_t;

  // Message word k lands in the wrapper's reversed register order (W0 -> reg 15).
  function automatic logic [4:0] msg_addr(input logic [3:0] k);
    return MSG_BASE + 5'(MSG_WORDS - 1) - {1'b0, k};
  endfunction

endpackage

// File: rtl/sha256_seq_digest_buf.sv
// 8x32 digest capture buffer: indexed writes from the read pipeline,
// sequential read pointer with a last-slot flag for the output stream.
module sha256_seq_digest_buf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_idx,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_adv,
  output logic [31:0] o_rd_data,
  output logic        o_rd_last
);
  import sha256_seq_pkg::*;

  logic [31:0] r_mem [DIG_WORDS];
  logic [2:0]  r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DIG_WORDS; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
      // Pointer wraps to slot 0 after the last word, ready for the next job.
      if (i_rd_adv) r_rd_ptr <= r_rd_ptr + 3'd1;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_rd_last = (r_rd_ptr == 3'(DIG_WORDS - 1));

endmodule

// File: rtl/sha256_block_sequencer.sv
// Streams one 512-bit block into the SHA-256 wrapper, starts it, waits, reads the digest back
// and streams it out. Define SHA256_SEQ_BLKCNT_EN to add the oBlockCount completed-job counter.
module sha256_block_sequencer #(
  parameter int unsigned WAIT_CYCLES  = 70,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] START_CMD    = 32'd1
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iMsgValid,
  output logic        oMsgReady,
  input  logic [31:0] iMsgData,
  output logic        oDigValid,
  input  logic        iDigReady,
  output logic [31:0] oDigData,
  output logic        oDigLast,
  output logic        oBusy,
`ifdef SHA256_SEQ_BLKCNT_EN
  output logic [31:0] oBlockCount,
`endif
  output logic        oCoreChipSelect_n,
  output logic        oCoreWrite_n,
  output logic        oCoreRead_n,
  output logic [4:0]  oCoreAddress,
  output logic [31:0] oCoreData,
  input  logic [31:0] iCoreData
);
  import sha256_seq_pkg::*;

  localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);

  seq_state_t r_state, w_state_nxt;

  logic [3:0]        r_word_cnt, w_word_cnt_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [2:0]        r_rd_cnt, w_rd_cnt_nxt;
  logic              r_rd_done, w_rd_done_nxt;
  logic              r_msg_ready, w_msg_ready_nxt;

  logic              r_cs_n, w_cs_n_nxt;
  logic              r_wr_n, w_wr_n_nxt;
  logic              r_rd_n, w_rd_n_nxt;
  logic [4:0]        r_addr, w_addr_nxt;
  logic [31:0]       r_data, w_data_nxt;

  // Stage 0 lines up with the read strobe; stage READ_LATENCY with valid iCoreData.
  logic [READ_LATENCY:0] r_pipe_vld;
  logic [2:0]            r_pipe_idx [READ_LATENCY+1];
  logic                  w_issue;

  logic        w_msg_acc;
  logic        w_dig_acc;
  logic        w_cap_en;
  logic [2:0]  w_cap_idx;
  logic [31:0] w_buf_data;
  logic        w_buf_last;

  assign w_msg_acc = iMsgValid & r_msg_ready;
  assign w_dig_acc = oDigValid & iDigReady;
  assign w_cap_en  = r_pipe_vld[READ_LATENCY];
  assign w_cap_idx = r_pipe_idx[READ_LATENCY];

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rd_done_nxt  = r_rd_done;
    w_cs_n_nxt     = 1'b1;
    w_wr_n_nxt     = 1'b1;
    w_rd_n_nxt     = 1'b1;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_issue        = 1'b0;

    case (r_state)
      IDLE, LOAD: begin
        if (w_msg_acc) begin
          w_cs_n_nxt = 1'b0;
          w_wr_n_nxt = 1'b0;
          w_addr_nxt = msg_addr(r_word_cnt);
          w_data_nxt = iMsgData;
          if (r_word_cnt == 4'(MSG_WORDS - 1)) begin
            w_word_cnt_nxt = '0;
            w_state_nxt    = START;
          end else begin
            w_word_cnt_nxt = r_word_cnt + 4'd1;
            w_state_nxt    = LOAD;
          end
        end
      end
      START: begin
        w_cs_n_nxt     = 1'b0;
        w_wr_n_nxt     = 1'b0;
        w_addr_nxt     = CTRL_ADDR;
        w_data_nxt     = START_CMD;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        // WAIT is entered in the start-write cycle, so leaving after WAIT_CYCLES states
        // puts the first registered read strobe WAIT_CYCLES+1 cycles after that write.
        if (r_wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) begin
          w_rd_cnt_nxt  = '0;
          w_rd_done_nxt = 1'b0;
          w_state_nxt   = READ;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      READ: begin
        if (!r_rd_done) begin
          w_cs_n_nxt   = 1'b0;
          w_rd_n_nxt   = 1'b0;
          w_addr_nxt   = DIG_BASE + {2'b00, r_rd_cnt};
          w_issue      = 1'b1;
          w_rd_cnt_nxt = r_rd_cnt + 3'd1;
          if (r_rd_cnt == 3'(DIG_WORDS - 1)) w_rd_done_nxt = 1'b1;
        end
        if (w_cap_en && (w_cap_idx == 3'(DIG_WORDS - 1))) w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_dig_acc && w_buf_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_msg_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_word_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_rd_done   <= 1'b0;
      r_msg_ready <= 1'b0;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_addr      <= '0;
      r_data      <= '0;
      r_pipe_vld  <= '0;
      for (int unsigned i = 0; i <= READ_LATENCY; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_word_cnt    <= w_word_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_rd_cnt      <= w_rd_cnt_nxt;
      r_rd_done     <= w_rd_done_nxt;
      r_msg_ready   <= w_msg_ready_nxt;
      r_cs_n        <= w_cs_n_nxt;
      r_wr_n        <= w_wr_n_nxt;
      r_rd_n        <= w_rd_n_nxt;
      r_addr        <= w_addr_nxt;
      r_data        <= w_data_nxt;
      r_pipe_vld[0] <= w_issue;
      r_pipe_idx[0] <= r_rd_cnt;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  sha256_seq_digest_buf u_digest_buf (
    .i_clk     (iClk),
    .i_rst_n   (iReset_n),
    .i_wr_en   (w_cap_en),
    .i_wr_idx  (w_cap_idx),
    .i_wr_data (iCoreData),
    .i_rd_adv  (w_dig_acc),
    .o_rd_data (w_buf_data),
    .o_rd_last (w_buf_last)
  );

`ifdef SHA256_SEQ_BLKCNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)                 r_blk_cnt <= '0;
    else if (w_dig_acc && w_buf_last) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign oBlockCount = r_blk_cnt;
`endif

  assign oMsgReady         = r_msg_ready;
  assign oBusy             = (r_state != IDLE);
  assign oDigValid         = (r_state == EMIT);
  assign oDigData          = oDigValid ? w_buf_data : '0;
  assign oDigLast          = oDigValid & w_buf_last;
  assign oCoreChipSelect_n = r_cs_n;
  assign oCoreWrite_n      = r_wr_n;
  assign oCoreRead_n       = r_rd_n;
  assign oCoreAddress      = r_addr;
  assign oCoreData         = r_data;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer with a behavioural SHA-256 wrapper model.
// Build with SHA256_SEQ_BLKCNT_EN defined to also check oBlockCount.
module tb_sha256_block_sequencer;

  localparam int unsigned WAIT_CYCLES = 70;
  localparam logic [31:0] START_CMD   = 32'd1;

  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [75:0]  RST_VEC   = {4'b0000, 32'h0, 3'b111, 5'h0, 32'h0};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] H_INIT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] msg_data = '0;
  logic        dig_valid;
  logic        dig_ready = 1'b1;
  logic [31:0] dig_data;
  logic        dig_last;
  logic        busy;
  logic        cs_n, wr_n, rd_n;
  logic [4:0]  addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata = '0;
`ifdef SHA256_SEQ_BLKCNT_EN
  logic [31:0] blk_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit stall    = 1'b0;

  logic [36:0] bus_q [$];
  logic [32:0] dig_q [$];
  int cyc = 0, start_cyc = 0, last_rd = 0, rd_k = 0, acc_cnt = 0, jobs_done = 0;
  bit in_wait = 1'b0, blocked = 1'b0;

  sha256_block_sequencer #(
    .WAIT_CYCLES  (WAIT_CYCLES),
    .READ_LATENCY (1),
    .START_CMD    (START_CMD)
  ) dut (
    .iClk              (clk),
    .iReset_n          (rst_n),
    .iMsgValid         (msg_valid),
    .oMsgReady         (msg_ready),
    .iMsgData          (msg_data),
    .oDigValid         (dig_valid),
    .iDigReady         (dig_ready),
    .oDigData          (dig_data),
    .oDigLast          (dig_last),
    .oBusy             (busy),
`ifdef SHA256_SEQ_BLKCNT_EN
    .oBlockCount       (blk_cnt),
`endif
    .oCoreChipSelect_n (cs_n),
    .oCoreWrite_n      (wr_n),
    .oCoreRead_n       (rd_n),
    .oCoreAddress      (addr),
    .oCoreData         (core_wdata),
    .iCoreData         (core_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = H_INIT;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H_INIT[255:224], b + H_INIT[223:192], c + H_INIT[191:160], d + H_INIT[159:128],
            e + H_INIT[127:96],  f + H_INIT[95:64],   g + H_INIT[63:32],   h + H_INIT[31:0]};
  endfunction

  // Wrapper model: reg 15 holds W0; a start write computes the digest into regs 16..23.
  logic [31:0] wregs [32];
  initial begin
    logic [511:0] m;
    logic [255:0] dg;
    for (int i = 0; i < 32; i++) wregs[i] = '0;
    forever begin
      @(posedge clk);
      if (!cs_n && !wr_n) begin
        wregs[addr] = core_wdata;
        if (addr == 5'd24 && core_wdata == 32'd1) begin
          for (int i = 0; i < 16; i++) m[511-32*i -: 32] = wregs[15-i];
          dg = sha256_blk(m);
          for (int i = 0; i < 8; i++) wregs[16+i] = dg[255-32*i -: 32];
        end
      end
      if (!cs_n && !rd_n) core_rdata <= wregs[addr];
    end
  end

  initial forever begin
    @(posedge clk);
    #1 dig_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: bus protocol, wait timing, ready hold-off and digest scoreboard.
  initial forever begin
    logic [36:0] eb;
    logic [32:0] ed;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      bus_q.delete();
      dig_q.delete();
      in_wait = 1'b0; blocked = 1'b0; acc_cnt = 0; rd_k = 0; jobs_done = 0;
    end else begin
      if (blocked) check("msg_ready_blocked", 80'(msg_ready), 80'(0));
      if (msg_valid && msg_ready) begin
        acc_cnt++;
        if (acc_cnt == 16) begin blocked = 1'b1; acc_cnt = 0; end
      end
      if (!cs_n) begin
        check("bus_one_strobe", 80'(wr_n ^ rd_n), 80'(1));
        if (in_wait && rd_n) fail_now("bus_during_wait");
        if (!wr_n) begin
          if (bus_q.size() == 0) fail_now("bus_write_unexpected");
          else begin
            eb = bus_q.pop_front();
            check("bus_write", 80'({addr, core_wdata}), 80'(eb));
            if (eb[36:32] == 5'd24) begin
              start_cyc = cyc; in_wait = 1'b1; rd_k = 0;
            end
          end
        end else if (!rd_n) begin
          if (in_wait) begin
            check("first_read_gap", 80'(cyc - start_cyc), 80'(WAIT_CYCLES + 1));
            in_wait = 1'b0;
          end else begin
            check("read_back_to_back", 80'(cyc - last_rd), 80'(1));
          end
          check("read_addr", 80'(addr), 80'(16 + rd_k));
          last_rd = cyc;
          rd_k++;
        end
      end
      if (dig_valid) begin
        if (dig_q.size() == 0) fail_now("digest_unexpected");
        else if (dig_ready) begin
          ed = dig_q.pop_front();
          check("digest_word", 80'({dig_last, dig_data}), 80'(ed));
          if (dig_last) begin jobs_done++; blocked = 1'b0; end
        end else begin
          check("digest_stall_hold", 80'({dig_last, dig_data}), 80'(dig_q[0]));
        end
      end
    end
  end

  task automatic run_job(input logic [511:0] msg, input logic [255:0] dig, input bit gaps);
    int n;
    for (int k = 0; k < 16; k++) bus_q.push_back({5'(15 - k), msg[511-32*k -: 32]});
    bus_q.push_back({5'd24, START_CMD});
    for (int i = 0; i < 8; i++) dig_q.push_back({(i == 7), dig[255-32*i -: 32]});
    for (int k = 0; k < 16; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      msg_valid = 1'b1;
      msg_data  = msg[511-32*k -: 32];
      n = 0;
      @(negedge clk);
      while (!msg_ready && n < 2000) begin @(negedge clk); n++; end
      if (!msg_ready) begin
        fail_now("msg_accept_timeout");
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    msg_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (dig_q.size() != 0 && n < 4000) begin @(posedge clk); n++; end
    if (dig_q.size() != 0) fail_now("digest_drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check("reset_state", 80'({msg_ready, dig_valid, dig_last, busy, dig_data, cs_n, wr_n, rd_n, addr, core_wdata}),
             80'(RST_VEC));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Abandon a job mid-WAIT with an asynchronous reset.
    run_job(MSG_ABC, DIG_ABC, 1'b0);
    n = 0;
    while (!in_wait && n < 500) begin @(posedge clk); n++; end
    if (!in_wait) fail_now("wait_phase_timeout");
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_mid_wait", 80'({msg_ready, dig_valid, dig_last, busy, dig_data, cs_n, wr_n, rd_n, addr, core_wdata}),
             80'(RST_VEC));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(MSG_ABC, DIG_ABC, 1'b0);
    drain();
    run_job(MSG_EMPTY, DIG_EMPTY, 1'b0);
    drain();

    stall = 1'b1;
    run_job(MSG_ABC, DIG_ABC, 1'b1);
    run_job(MSG_EMPTY, DIG_EMPTY, 1'b1);
    drain();
    stall = 1'b0;

    run_job(MSG_ABC, DIG_ABC, 1'b0);
    run_job(MSG_EMPTY, DIG_EMPTY, 1'b0);
    drain();

    check("jobs_completed", 80'(jobs_done), 80'(6));
    check("idle_outputs", 80'({busy, dig_valid, msg_ready}), 80'(3'b001));
`ifdef SHA256_SEQ_BLKCNT_EN
    check("block_count", 80'(blk_cnt), 80'(6));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
